// File: rtl/bit_secme_birimi_pkg.sv
// Shared definitions for the select unit: FSM state encoding, not-found index
// and the chunk-width legality helper.
package bit_secme_birimi_pkg;

    typedef enum logic [1:0] {
        BOSTA = 2'b00,
        TARA  = 2'b01,
        BITTI = 2'b10
    } durum_t;

    localparam logic [5:0] BULUNAMADI_INDEKS = 6'd32;

    function automatic bit parca_genisligi_gecerli(input int genislik);
        return (genislik == 4) || (genislik == 8) || (genislik == 16);
    endfunction

endpackage

// File: rtl/bit_secme_birimi_parca_secici.sv
// Combinational chunk selector: population count of the chunk, and the position
// of the sira_i-th set bit (LSB first) when the chunk holds enough set bits.
module parca_secici #(
    parameter int GENISLIK = 8,
    parameter int POS_W    = $clog2(GENISLIK)
) (
    input  logic [GENISLIK-1:0] parca_i,
    input  logic [4:0]          sira_i,
    output logic [4:0]          sayi_o,
    output logic                isabet_o,
    output logic [POS_W-1:0]    konum_o
);

    logic [4:0] sayac;

    // The running count only equals sira_i at one set bit, so the hit is unique.
    always_comb begin
        sayac    = 5'd0;
        isabet_o = 1'b0;
        konum_o  = '0;
        for (int i = 0; i < GENISLIK; i++) begin
            if (parca_i[i]) begin
                if (sayac == sira_i) begin
                    isabet_o = 1'b1;
                    konum_o  = POS_W'(i);
                end
                sayac = sayac + 5'd1;
            end
        end
        sayi_o = sayac;
    end

endmodule

// File: rtl/bit_secme_birimi.sv
// Iterative select unit: index of the k-th set bit of a 32-bit word, one chunk per cycle.
// Define BIT_SECME_ERKEN_CIKIS_EN to stop at the hit chunk; default is constant-time.
module bit_secme_birimi
    import bit_secme_birimi_pkg::*;
#(
    parameter int PARCA_GENISLIGI = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        basla_i,
    input  logic [31:0] deger_i,
    input  logic [4:0]  sira_i,
    output logic        hazir_o,
    output logic        gecerli_o,
    output logic [5:0]  sonuc_o,
    output logic        bulunamadi_o
);

    localparam int PARCA_SAYISI = 32 / PARCA_GENISLIGI;
    localparam int SAYAC_W      = $clog2(PARCA_SAYISI);
    localparam int POS_W        = $clog2(PARCA_GENISLIGI);

    if (!parca_genisligi_gecerli(PARCA_GENISLIGI)) begin : g_hatali_genislik
        $error("PARCA_GENISLIGI must be 4, 8 or 16");
    end

    durum_t             durum_q, durum_d;
    logic [31:0]        veri_q, veri_d;
    logic [4:0]         kalan_q, kalan_d;
    logic [SAYAC_W-1:0] parca_q, parca_d;
    logic               bulundu_q, bulundu_d;
    logic [5:0]         indeks_q, indeks_d;
    logic [5:0]         sonuc_q, sonuc_d;
    logic               bulunamadi_q, bulunamadi_d;

    logic [4:0]         parca_sayi;
    logic               parca_isabet;
    logic [POS_W-1:0]   parca_konum;
    logic               yeni_isabet;
    logic               son_parca;
    logic               bitir;
    logic               kabul;
    logic [5:0]         aday_indeks;

    // The word is shifted down each cycle so the current chunk is always the low bits.
    parca_secici #(
        .GENISLIK (PARCA_GENISLIGI),
        .POS_W    (POS_W)
    ) u_parca_secici (
        .parca_i  (veri_q[PARCA_GENISLIGI-1:0]),
        .sira_i   (kalan_q),
        .sayi_o   (parca_sayi),
        .isabet_o (parca_isabet),
        .konum_o  (parca_konum)
    );

    assign kabul       = basla_i && (durum_q != TARA);
    assign yeni_isabet = parca_isabet && !bulundu_q;
    assign son_parca   = (parca_q == SAYAC_W'(PARCA_SAYISI - 1));
    assign aday_indeks = 6'({parca_q, parca_konum});

`ifdef BIT_SECME_ERKEN_CIKIS_EN
    assign bitir = son_parca || yeni_isabet;
`else
    assign bitir = son_parca;
`endif

    always_comb begin
        durum_d      = durum_q;
        veri_d       = veri_q;
        kalan_d      = kalan_q;
        parca_d      = parca_q;
        bulundu_d    = bulundu_q;
        indeks_d     = indeks_q;
        sonuc_d      = sonuc_q;
        bulunamadi_d = bulunamadi_q;

        case (durum_q)
            TARA: begin
                veri_d  = veri_q >> PARCA_GENISLIGI;
                parca_d = parca_q + SAYAC_W'(1);
                if (yeni_isabet) begin
                    bulundu_d = 1'b1;
                    indeks_d  = aday_indeks;
                end else if (!bulundu_q) begin
                    kalan_d = kalan_q - parca_sayi;
                end
                // Outputs change only when the result is published, not mid-scan.
                if (bitir) begin
                    durum_d      = BITTI;
                    sonuc_d      = yeni_isabet ? aday_indeks :
                                   (bulundu_q ? indeks_q : BULUNAMADI_INDEKS);
                    bulunamadi_d = !(yeni_isabet || bulundu_q);
                end
            end
            BITTI:   durum_d = BOSTA;
            default: durum_d = BOSTA;
        endcase

        if (kabul) begin
            durum_d   = TARA;
            veri_d    = deger_i;
            kalan_d   = sira_i;
            parca_d   = '0;
            bulundu_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            durum_q      <= BOSTA;
            veri_q       <= '0;
            kalan_q      <= '0;
            parca_q      <= '0;
            bulundu_q    <= 1'b0;
            indeks_q     <= '0;
            sonuc_q      <= '0;
            bulunamadi_q <= 1'b0;
        end else begin
            durum_q      <= durum_d;
            veri_q       <= veri_d;
            kalan_q      <= kalan_d;
            parca_q      <= parca_d;
            bulundu_q    <= bulundu_d;
            indeks_q     <= indeks_d;
            sonuc_q      <= sonuc_d;
            bulunamadi_q <= bulunamadi_d;
        end
    end

    assign hazir_o      = (durum_q != TARA);
    assign gecerli_o    = (durum_q == BITTI);
    assign sonuc_o      = sonuc_q;
    assign bulunamadi_o = bulunamadi_q;

endmodule

// File: tb/tb_bit_secme_birimi.sv
// Self-checking bench for bit_secme_birimi: directed cases plus randomized jobs
// scored against a bit-level reference model (result, not-found flag, latency).
module tb_bit_secme_birimi;

    localparam int W  = 8;
    localparam int PS = 32 / W;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        basla_i;
    logic [31:0] deger_i;
    logic [4:0]  sira_i;
    logic        hazir_o;
    logic        gecerli_o;
    logic [5:0]  sonuc_o;
    logic        bulunamadi_o;

    bit_secme_birimi #(.PARCA_GENISLIGI(W)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .basla_i      (basla_i),
        .deger_i      (deger_i),
        .sira_i       (sira_i),
        .hazir_o      (hazir_o),
        .gecerli_o    (gecerli_o),
        .sonuc_o      (sonuc_o),
        .bulunamadi_o (bulunamadi_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [5:0] sonuc;
        logic       bul;
        int         cyc;
    } beklenti_t;

    beklenti_t  bekq[$];
    logic [5:0] m_sonuc = 6'd0;
    logic       m_bul   = 1'b0;

    task automatic kontrol(input string ad, input logic [31:0] gercek, input logic [31:0] beklenen);
        checks++;
        if (gercek !== beklenen) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", ad, gercek, beklenen, cyc);
        end
    endtask

    // Reference: walk bits LSB first counting ones.
    function automatic logic [5:0] ref_sonuc(input logic [31:0] d, input logic [4:0] k);
        int n = 0;
        for (int i = 0; i < 32; i++) begin
            if (d[i]) begin
                if (n == int'(k)) return 6'(i);
                n++;
            end
        end
        return 6'd32;
    endfunction

    function automatic int ref_gecikme(input logic [5:0] s);
`ifdef BIT_SECME_ERKEN_CIKIS_EN
        if (s == 6'd32) return PS + 1;
        return int'(s) / W + 2;
`else
        return PS + 1;
`endif
    endfunction

    task automatic sonraki();
        @(negedge clk_i);
        #1;
    endtask

    // Start a job this cycle; expectation enters the scoreboard.
    task automatic baslat_ham(input logic [31:0] d, input logic [4:0] k,
                              input logic [5:0] s, input logic b, input int lat);
        beklenti_t e;
        kontrol("hazir_kabul", hazir_o, 1);
        basla_i = 1'b1;
        deger_i = d;
        sira_i  = k;
        e.sonuc = s;
        e.bul   = b;
        e.cyc   = cyc + lat;
        bekq.push_back(e);
        $display("job deger=%08h k=%0d -> sonuc=%0d bul=%0d at cycle %0d", d, k, s, b, e.cyc);
        sonraki();
        basla_i = 1'b0;
    endtask

    task automatic baslat(input logic [31:0] d, input logic [4:0] k);
        logic [5:0] s;
        s = ref_sonuc(d, k);
        baslat_ham(d, k, s, s == 6'd32, ref_gecikme(s));
    endtask

    // Directed job with hand-computed expectations; also pins the model.
    task automatic baslat_lit(input logic [31:0] d, input logic [4:0] k,
                              input logic [5:0] s, input logic b, input int lat);
        kontrol("model_sonuc", ref_sonuc(d, k), s);
        kontrol("model_gecikme", ref_gecikme(s), lat);
        baslat_ham(d, k, s, b, lat);
    endtask

    task automatic bekle_bitti();
        int n = 0;
        while (!gecerli_o && n < 40) begin
            sonraki();
            n++;
        end
        if (!gecerli_o) kontrol("bitti_zaman_asimi", 0, 1);
    endtask

    // Compare process: every cycle, outputs vs. scoreboard and held result.
    always @(negedge clk_i) begin
        beklenti_t e;
        if (rst_i) begin
            bekq.delete();
            m_sonuc = 6'd0;
            m_bul   = 1'b0;
            kontrol("reset_hazir", hazir_o, 1);
            kontrol("reset_gecerli", gecerli_o, 0);
            kontrol("reset_sonuc", sonuc_o, 0);
            kontrol("reset_bul", bulunamadi_o, 0);
        end else begin
            kontrol("hazir", hazir_o, (bekq.size() == 0 || bekq[0].cyc == cyc) ? 1 : 0);
            if (gecerli_o) begin
                if (bekq.size() == 0) begin
                    kontrol("beklenmeyen_gecerli", 1, 0);
                end else begin
                    e = bekq.pop_front();
                    kontrol("gecikme_cycle", cyc, e.cyc);
                    m_sonuc = e.sonuc;
                    m_bul   = e.bul;
                end
            end else if (bekq.size() > 0 && cyc >= bekq[0].cyc) begin
                kontrol("gecerli_eksik", 0, 1);
                void'(bekq.pop_front());
            end
            kontrol("sonuc", sonuc_o, m_sonuc);
            kontrol("bulunamadi", bulunamadi_o, m_bul);
        end
    end

    initial begin
        logic [31:0] d;
        logic [4:0]  k;
        int          sel, pc, gap;
`ifdef BIT_SECME_ERKEN_CIKIS_EN
        int lat1 = 2, lat4a = 4, lat4b = 2;
`else
        int lat1 = PS + 1, lat4a = PS + 1, lat4b = PS + 1;
`endif
        rst_i   = 1'b1;
        basla_i = 1'b0;
        deger_i = '0;
        sira_i  = '0;
        repeat (3) sonraki();
        rst_i = 1'b0;
        sonraki();

        baslat_lit(32'h0000_0001, 5'd0, 6'd0, 1'b0, lat1);
        bekle_bitti();
        sonraki();
        baslat_lit(32'h8000_0000, 5'd0, 6'd31, 1'b0, 5);
        bekle_bitti();
        sonraki();
        baslat_lit(32'hFFFF_FFFF, 5'd31, 6'd31, 1'b0, 5);
        bekle_bitti();
        sonraki();
        baslat_lit(32'h0F0F_0000, 5'd8, 6'd32, 1'b1, 5);
        bekle_bitti();
        sonraki();
        baslat_lit(32'h0000_0000, 5'd0, 6'd32, 1'b1, 5);
        bekle_bitti();
        sonraki();

        // Back-to-back: start again in the result cycle.
        baslat_lit(32'h0001_0100, 5'd1, 6'd16, 1'b0, lat4a);
        bekle_bitti();
        baslat_lit(32'h0000_0002, 5'd0, 6'd1, 1'b0, lat4b);
        bekle_bitti();
        sonraki();

        // Start held high with other data while scanning must be ignored.
        baslat_lit(32'h8000_0000, 5'd0, 6'd31, 1'b0, 5);
        basla_i = 1'b1;
        deger_i = 32'h0000_0001;
        sira_i  = 5'd0;
        repeat (3) sonraki();
        basla_i = 1'b0;
        bekle_bitti();
        sonraki();

        // Reset mid-scan: no pulse, reset values.
        baslat_lit(32'h8000_0000, 5'd0, 6'd31, 1'b0, 5);
        sonraki();
        rst_i = 1'b1;
        repeat (2) sonraki();
        rst_i = 1'b0;
        repeat (8) sonraki();
        kontrol("reset_sonrasi_sonuc", sonuc_o, 0);
        kontrol("reset_sonrasi_hazir", hazir_o, 1);

        for (int j = 0; j < 3000; j++) begin
            sel = $urandom_range(0, 9);
            case (sel)
                0:       d = 32'h0;
                1, 2, 3: d = $urandom & $urandom & $urandom;
                4:       d = 32'hFFFF_FFFF;
                default: d = $urandom;
            endcase
            pc = $countones(d);
            if ($urandom_range(0, 1) == 0 && pc > 0)
                k = 5'($urandom_range(0, (pc > 31) ? 31 : pc));
            else
                k = 5'($urandom_range(0, 31));
            baslat(d, k);
            bekle_bitti();
            gap = $urandom_range(0, 3);
            repeat (gap) sonraki();
        end
        repeat (10) sonraki();
        kontrol("bekleyen_is", bekq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
